instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 26 ++
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port plus the handoff to decode.
// The master side is the fetch unit; the slave side is memory/decode.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  op;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        redirect;
    logic [31:0] redirect_target;

    modport master (
        output imem_req, imem_addr, instr, op, instr_valid, pc, pcplus4,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, op, instr_valid, pc, pcplus4,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_target
    );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: requests one word at a time, holds it for decode
// and squashes in-flight data on redirect.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StHold, StFlush} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pend_q, pend_d;
    logic        valid_q, valid_d;
    logic [31:0] target;
    logic        unused_tgt_lsbs;

    assign target          = {bus.redirect_target[31:2], 2'b00};
    assign unused_tgt_lsbs = ^bus.redirect_target[1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pend_d     = pend_q;
        valid_d    = valid_q;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (bus.redirect) begin
                    fetch_pc_d = target;
                end
            end
            StReq: begin
                if (bus.redirect) begin
                    if (bus.imem_ack) begin
                        // Returned word belongs to the squashed path; reissue at the target.
                        fetch_pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = StFlush;
                    end
                end else if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    pc_d    = fetch_pc_q;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.redirect) begin
                    fetch_pc_d = target;
                    valid_d    = 1'b0;
                    instr_d    = NOP_INSTR;
                    state_d    = StReq;
                end else if (bus.instr_ready) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    valid_d    = 1'b0;
                    instr_d    = NOP_INSTR;
                    state_d    = StReq;
                end
            end
            StFlush: begin
                // Request address stays put until the stale ack drains.
                if (bus.imem_ack) begin
                    fetch_pc_d = bus.redirect ? target : pend_q;
                    state_d    = StReq;
                end else if (bus.redirect) begin
                    pend_d = target;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pend_q     <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.imem_req    = (state_q == StReq) || (state_q == StFlush);
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr       = instr_q;
    assign bus.op          = instr_q[6:0];
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.pcplus4     = pc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scenarios plus a randomized run against a transaction-level fetch model.
module tb_instr_fetch;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC0  = 32'h0000_0000;
    localparam logic [31:0] RPC1  = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    instr_fetch_if if0 ();
    instr_fetch_if if1 ();

    instr_fetch #(.RESET_PC(RPC0), .NOP_INSTR(NOP)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    instr_fetch #(.RESET_PC(RPC1), .NOP_INSTR(NOP)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    // Apply inputs to both instances for one cycle, then land on the next negedge.
    task automatic tick(input logic rst, input logic rd, input logic [31:0] tgt, input logic rdy,
                        input logic ack, input logic [31:0] data);
        reset               = rst;
        if0.redirect        = rd;
        if0.redirect_target = tgt;
        if0.instr_ready     = rdy;
        if0.imem_ack        = ack;
        if0.imem_rdata      = data;
        if1.redirect        = rd;
        if1.redirect_target = tgt;
        if1.instr_ready     = rdy;
        if1.imem_ack        = ack;
        if1.imem_rdata      = data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (if0.imem_req !== 1'b0) begin errors++;
            $display("FAIL reset_req: got %b expected 0", if0.imem_req); end
        checks++; if (if0.instr_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b expected 0", if0.instr_valid); end
        checks++; if (if0.instr !== NOP) begin errors++;
            $display("FAIL reset_instr: got %h expected %h", if0.instr, NOP); end
        checks++; if (if0.op !== 7'b0010011) begin errors++;
            $display("FAIL reset_op: got %b expected 0010011", if0.op); end
        checks++; if (if0.pc !== RPC0 || if0.pcplus4 !== RPC0 + 32'd4) begin errors++;
            $display("FAIL reset_pc: got %h/%h expected %h/%h", if0.pc, if0.pcplus4, RPC0,
                     RPC0 + 32'd4); end
        checks++; if (if1.pc !== RPC1 || if1.pcplus4 !== 32'h0) begin errors++;
            $display("FAIL reset_pc_hi: got %h/%h expected %h/0", if1.pc, if1.pcplus4, RPC1); end
    endtask

    task automatic test_first_fetch();
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (if0.imem_req !== 1'b1 || if0.imem_addr !== 32'h0) begin errors++;
            $display("FAIL first_req: got %b/%h expected 1/0", if0.imem_req, if0.imem_addr); end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0033);
        checks++; if (if0.instr_valid !== 1'b1 || if0.op !== 7'b0110011) begin errors++;
            $display("FAIL first_valid: got %b/%b expected 1/0110011", if0.instr_valid, if0.op); end
        checks++; if (if0.pc !== 32'h0 || if0.pcplus4 !== 32'h4 || if0.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL first_pc: got %h/%h/%b expected 0/4/0", if0.pc, if0.pcplus4,
                     if0.imem_req); end
    endtask

    task automatic test_hold_stall();
        // Spurious acks while idle on the memory side must be ignored.
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b0, i[0], 32'hBAD0_0000 + i);
            checks++;
            if (if0.instr_valid !== 1'b1 || if0.instr !== 32'h33 || if0.pc !== 32'h0 ||
                if0.pcplus4 !== 32'h4 || if0.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got v=%b i=%h pc=%h p4=%h req=%b expected 1/33/0/4/0",
                         i, if0.instr_valid, if0.instr, if0.pc, if0.pcplus4, if0.imem_req);
            end
        end
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (if0.imem_req !== 1'b1 || if0.imem_addr !== 32'h4) begin errors++;
            $display("FAIL accept_next: got %b/%h expected 1/4", if0.imem_req, if0.imem_addr); end
        checks++; if (if0.instr_valid !== 1'b0 || if0.instr !== NOP) begin errors++;
            $display("FAIL accept_nop: got %b/%h expected 0/%h", if0.instr_valid, if0.instr, NOP); end
    endtask

    task automatic test_redirect_flush();
        tick(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (if0.imem_req !== 1'b1 || if0.imem_addr !== 32'h4 || if0.instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_hold[%0d]: got %b/%h/%b expected 1/4/0", i, if0.imem_req,
                         if0.imem_addr, if0.instr_valid);
            end
            tick(1'b0, 1'b0, 32'h0, 1'b0, i == 2, 32'hDEAD_BEEF);
        end
        checks++;
        if (if0.instr_valid !== 1'b0 || if0.instr !== NOP || if0.imem_req !== 1'b1 ||
            if0.imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL flush_drain: got v=%b i=%h req=%b a=%h expected 0/%h/1/100",
                     if0.instr_valid, if0.instr, if0.imem_req, if0.imem_addr, NOP);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00B3);
        checks++; if (if0.instr_valid !== 1'b1 || if0.pc !== 32'h100 || if0.instr !== 32'hB3) begin
            errors++;
            $display("FAIL flush_refetch: got %b/%h/%h expected 1/100/b3", if0.instr_valid,
                     if0.pc, if0.instr); end
    endtask

    task automatic test_redirect_hold();
        tick(1'b0, 1'b1, 32'h0000_2002, 1'b1, 1'b0, 32'h0);
        checks++;
        if (if0.instr_valid !== 1'b0 || if0.imem_req !== 1'b1 || if0.imem_addr !== 32'h2000) begin
            errors++;
            $display("FAIL redirect_hold: got %b/%b/%h expected 0/1/2000", if0.instr_valid,
                     if0.imem_req, if0.imem_addr);
        end
    endtask

    task automatic test_reset_in_flush();
        tick(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5677);
        checks++;
        if (if0.imem_req !== 1'b0 || if0.instr_valid !== 1'b0 || if0.instr !== NOP) begin
            errors++;
            $display("FAIL flush_reset: got %b/%b/%h expected 0/0/%h", if0.imem_req,
                     if0.instr_valid, if0.instr, NOP);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (if0.imem_req !== 1'b1 || if0.imem_addr !== RPC0 || if0.instr_valid !== 1'b0)
        begin errors++;
            $display("FAIL flush_reset_req: got %b/%h/%b expected 1/%h/0", if0.imem_req,
                     if0.imem_addr, if0.instr_valid, RPC0); end
    endtask

    task automatic test_wrap();
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (if1.imem_req !== 1'b1 || if1.imem_addr !== RPC1) begin errors++;
            $display("FAIL wrap_req: got %b/%h expected 1/%h", if1.imem_req, if1.imem_addr, RPC1); end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0033);
        checks++;
        if (if1.instr_valid !== 1'b1 || if1.pc !== RPC1 || if1.pcplus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: got %b/%h/%h expected 1/%h/0", if1.instr_valid, if1.pc,
                     if1.pcplus4, RPC1);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (if1.imem_req !== 1'b1 || if1.imem_addr !== 32'h0) begin errors++;
            $display("FAIL wrap_next: got %b/%h expected 1/0", if1.imem_req, if1.imem_addr); end
    endtask

    // Model: a request is either outstanding or not; a redirect marks the outstanding
    // request's data as dead and records where fetching resumes.
    task automatic test_random();
        logic        m_idle, m_req, m_valid, m_dead;
        logic [31:0] m_addr, m_instr, m_pc, m_resume;
        logic        rst, rd, rdy, ack;
        logic [31:0] tgt, data, exp_instr;
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) begin
                exp_instr = m_valid ? m_instr : NOP;
                checks++;
                if (if0.imem_req !== m_req || (m_req && if0.imem_addr !== m_addr) ||
                    if0.imem_addr[1:0] !== 2'b00) begin
                    errors++;
                    $display("FAIL rand_req[%0d]: got %b/%h expected %b/%h", i, if0.imem_req,
                             if0.imem_addr, m_req, m_addr);
                end
                checks++;
                if (if0.instr_valid !== m_valid || if0.instr !== exp_instr ||
                    if0.op !== exp_instr[6:0]) begin
                    errors++;
                    $display("FAIL rand_instr[%0d]: got %b/%h expected %b/%h", i,
                             if0.instr_valid, if0.instr, m_valid, exp_instr);
                end
                if (m_valid) begin
                    checks++;
                    if (if0.pc !== m_pc || if0.pcplus4 !== m_pc + 32'd4) begin
                        errors++;
                        $display("FAIL rand_pc[%0d]: got %h/%h expected %h/%h", i, if0.pc,
                                 if0.pcplus4, m_pc, m_pc + 32'd4);
                    end
                end
            end
            rst  = (i == 0) || ($urandom_range(0, 99) == 0);
            rd   = ($urandom_range(0, 7) == 0);
            tgt  = $urandom;
            rdy  = $urandom_range(0, 1) == 1;
            ack  = ($urandom_range(0, 2) == 0);
            data = $urandom;
            if (rst) begin
                m_idle = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_dead = 1'b0;
                m_addr = RPC0; m_pc = RPC0; m_instr = NOP; m_resume = 32'h0;
            end else if (m_idle) begin
                m_idle = 1'b0;
                m_req  = 1'b1;
                if (rd) m_addr = {tgt[31:2], 2'b00};
            end else if (m_req) begin
                if (ack && rd) begin
                    m_addr = {tgt[31:2], 2'b00};
                    m_dead = 1'b0;
                end else if (ack && m_dead) begin
                    m_addr = m_resume;
                    m_dead = 1'b0;
                end else if (ack) begin
                    m_req = 1'b0; m_valid = 1'b1; m_instr = data; m_pc = m_addr;
                end else if (rd) begin
                    m_dead   = 1'b1;
                    m_resume = {tgt[31:2], 2'b00};
                end
            end else if (m_valid && (rd || rdy)) begin
                m_valid = 1'b0;
                m_req   = 1'b1;
                m_addr  = rd ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
            end
            tick(rst, rd, tgt, rdy, ack, data);
        end
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_redirect_flush();
        test_redirect_hold();
        test_reset_in_flush();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
